// File: rtl/ram_sdp_sync_clr_if.sv
// ----------------------------------------------------------------------------
// ram_sdp_sync_clr_if
//   User-side bus of the simple-dual-port RAM with clear engine.
//
//   Signals:
//     clr_req     master->slave  request a full memory clear
//     busy        slave->master  high while the clear engine owns the array
//     we/waddr/din master->slave write port
//     re/raddr    master->slave  read port
//     dout        slave->master  read data (held between reads)
//     dout_valid  slave->master  one-cycle strobe for new data on dout
//
//   Modports: master (user side), slave (RAM side).
// ----------------------------------------------------------------------------
interface ram_sdp_sync_clr_if #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 14
);
    logic              clr_req;
    logic              busy;
    logic              we;
    logic [AWIDTH-1:0] waddr;
    logic [DWIDTH-1:0] din;
    logic              re;
    logic [AWIDTH-1:0] raddr;
    logic [DWIDTH-1:0] dout;
    logic              dout_valid;

    modport master (
        output clr_req, we, waddr, din, re, raddr,
        input  busy, dout, dout_valid
    );

    modport slave (
        input  clr_req, we, waddr, din, re, raddr,
        output busy, dout, dout_valid
    );
endinterface

// File: rtl/ram_sdp_sync_clr.sv
// ----------------------------------------------------------------------------
// ram_sdp_sync_clr
//   Simple-dual-port synchronous-read RAM (one write port, one read port)
//   with a hardware clear engine that writes CLR_VALUE to every word after
//   reset and on request.
//
//   Parameters:
//     AWIDTH    address width, DEPTH = 1 << AWIDTH
//     DWIDTH    data width
//     OUT_REG   0: 1-cycle read latency, 1: extra output register (2 cycles)
//     RD_MODE   same-address read/write: 0 = old data, 1 = new data
//     CLR_VALUE value written to every word during a clear
//
//   Ports:
//     clock     rising-edge clock
//     reset_n   asynchronous active-low reset
//     bus       ram_sdp_sync_clr_if.slave (clr_req, busy, we, waddr, din,
//               re, raddr, dout, dout_valid)
// ----------------------------------------------------------------------------
module ram_sdp_sync_clr #(
    parameter int              AWIDTH    = 3,
    parameter int              DWIDTH    = 14,
    parameter int              OUT_REG   = 0,
    parameter int              RD_MODE   = 0,
    parameter logic [DWIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    ram_sdp_sync_clr_if.slave   bus
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    logic [AWIDTH-1:0] r_clr_addr;
    logic              r_busy;

    logic [DWIDTH-1:0] r_mem [DEPTH];

    logic              w_mem_we;
    logic [AWIDTH-1:0] w_mem_addr;
    logic [DWIDTH-1:0] w_mem_data;
    logic              w_rd_en;
    logic              w_collide;
    logic [DWIDTH-1:0] w_rd_data;

    logic [DWIDTH-1:0] r_s1_data;
    logic              r_s1_valid;

    // Clear/ready FSM; busy is registered alongside the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + AWIDTH'(1);
                    if (&r_clr_addr) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (bus.clr_req) begin
                        r_state    <= ST_CLEAR;
                        r_clr_addr <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // The clear engine owns the single write port while clearing.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = bus.waddr;
        w_mem_data = bus.din;
        if (r_state == ST_CLEAR) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_clr_addr;
            w_mem_data = CLR_VALUE;
        end else if (bus.we) begin
            w_mem_we   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    assign w_rd_en   = (r_state == ST_READY) && bus.re;
    assign w_collide = (r_state == ST_READY) && bus.we && (bus.waddr == bus.raddr);
    // Array read returns pre-edge contents; write-first bypasses din instead.
    assign w_rd_data = ((RD_MODE != 0) && w_collide) ? bus.din : r_mem[bus.raddr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_en;
            if (w_rd_en) begin
                r_s1_data <= w_rd_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DWIDTH-1:0] r_s2_data;
            logic              r_s2_valid;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_s2_data  <= '0;
                    r_s2_valid <= 1'b0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign bus.dout       = r_s2_data;
            assign bus.dout_valid = r_s2_valid;
        end else begin : g_no_out_reg
            assign bus.dout       = r_s1_data;
            assign bus.dout_valid = r_s1_valid;
        end
    endgenerate

    assign bus.busy = r_busy;

endmodule

// File: tb/tb_ram_sdp_sync_clr.sv
// ----------------------------------------------------------------------------
// tb_ram_sdp_sync_clr
//   Two instances share stimulus: u_a (OUT_REG=0, RD_MODE=0, CLR_VALUE=0)
//   and u_b (OUT_REG=1, RD_MODE=1, CLR_VALUE=14'h0155). Expected read
//   results are queued with their due cycle when a read is driven and
//   checked when dout_valid is seen.
// ----------------------------------------------------------------------------
module tb_ram_sdp_sync_clr;

    localparam int AW = 3;
    localparam int DW = 14;
    localparam int unsigned DEPTH = 8;
    localparam logic [DW-1:0] CLR_B = 14'h0155;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    ram_sdp_sync_clr_if #(.AWIDTH(AW), .DWIDTH(DW)) ia ();
    ram_sdp_sync_clr_if #(.AWIDTH(AW), .DWIDTH(DW)) ib ();

    ram_sdp_sync_clr #(
        .AWIDTH(AW), .DWIDTH(DW), .OUT_REG(0), .RD_MODE(0), .CLR_VALUE(14'h0000)
    ) u_a (
        .clock(clock), .reset_n(reset_n), .bus(ia.slave)
    );

    ram_sdp_sync_clr #(
        .AWIDTH(AW), .DWIDTH(DW), .OUT_REG(1), .RD_MODE(1), .CLR_VALUE(CLR_B)
    ) u_b (
        .clock(clock), .reset_n(reset_n), .bus(ib.slave)
    );

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
    } exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] din;
        logic          re;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] model_a [DEPTH];
    logic [DW-1:0] model_b [DEPTH];
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;
    int unsigned   cyc = 0;
    int unsigned   clr_left = 0;
    int unsigned   clr_idx = 0;
    int unsigned   n_vec = 0;
    int unsigned   n_fail = 0;

    localparam int NV = 18;
    vec_t tbl [NV];

    // ---------------- output monitors ----------------
    always @(negedge clock) begin
        exp_t e;
        n_vec++;
        if (ia.dout_valid) begin
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL rd_a unexpected strobe: dout=%h cycle=%0d, required no strobe", ia.dout, cyc);
            end else begin
                e = qa.pop_front();
                if (ia.dout !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL rd_a: dout=%h at cycle %0d, required %h at cycle %0d", ia.dout, cyc, e.data, e.due);
                end
                last_a = e.data;
            end
        end else if (qa.size() != 0 && qa[0].due <= cyc) begin
            e = qa.pop_front();
            n_fail++;
            $display("FAIL rd_a missing strobe: none at cycle %0d, required %h at cycle %0d", cyc, e.data, e.due);
        end else if (ia.dout !== last_a) begin
            n_fail++;
            $display("FAIL hold_a: dout=%h, required %h", ia.dout, last_a);
        end
    end

    always @(negedge clock) begin
        exp_t e;
        n_vec++;
        if (ib.dout_valid) begin
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL rd_b unexpected strobe: dout=%h cycle=%0d, required no strobe", ib.dout, cyc);
            end else begin
                e = qb.pop_front();
                if (ib.dout !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL rd_b: dout=%h at cycle %0d, required %h at cycle %0d", ib.dout, cyc, e.data, e.due);
                end
                last_b = e.data;
            end
        end else if (qb.size() != 0 && qb[0].due <= cyc) begin
            e = qb.pop_front();
            n_fail++;
            $display("FAIL rd_b missing strobe: none at cycle %0d, required %h at cycle %0d", cyc, e.data, e.due);
        end else if (ib.dout !== last_b) begin
            n_fail++;
            $display("FAIL hold_b: dout=%h, required %h", ib.dout, last_b);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                         input logic re, input logic [AW-1:0] ra, input logic clr);
        ia.we = we; ia.waddr = wa; ia.din = d; ia.re = re; ia.raddr = ra; ia.clr_req = clr;
        ib.we = we; ib.waddr = wa; ib.din = d; ib.re = re; ib.raddr = ra; ib.clr_req = clr;
    endtask

    // One clock edge: update the reference model for the edge, queue any
    // read results, then check busy after the edge.
    task automatic tick(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                        input logic re, input logic [AW-1:0] ra, input logic clr,
                        input logic use_exp, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        exp_t e;
        drive(we, wa, d, re, ra, clr);
        if (clr_left > 0) begin
            model_a[clr_idx] = '0;
            model_b[clr_idx] = CLR_B;
            clr_idx++;
            clr_left--;
        end else begin
            if (re) begin
                if (!use_exp) begin
                    ea = model_a[ra];
                    eb = (we && wa == ra) ? d : model_b[ra];
                end
                e.data = ea; e.due = cyc + 1; qa.push_back(e);
                e.data = eb; e.due = cyc + 2; qb.push_back(e);
            end
            if (we) begin
                model_a[wa] = d;
                model_b[wa] = d;
            end
            if (clr) begin
                clr_left = DEPTH;
                clr_idx  = 0;
            end
        end
        @(posedge clock);
        cyc++;
        #1;
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        n_vec++;
        if (ia.busy !== (clr_left > 0)) begin
            n_fail++;
            $display("FAIL busy_a: busy=%0b at cycle %0d, required %0b", ia.busy, cyc, (clr_left > 0));
        end
        n_vec++;
        if (ib.busy !== (clr_left > 0)) begin
            n_fail++;
            $display("FAIL busy_b: busy=%0b at cycle %0d, required %0b", ib.busy, cyc, (clr_left > 0));
        end
    endtask

    task automatic idle();
        tick(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] d);
        tick(1'b1, wa, d, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] ra);
        tick(1'b0, '0, '0, 1'b1, ra, 1'b0, 1'b0, '0, '0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (ia.busy !== 1'b1 || ia.dout !== '0 || ia.dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: busy=%0b dout=%h valid=%0b, required 1/0000/0", ia.busy, ia.dout, ia.dout_valid);
        end
        n_vec++;
        if (ib.busy !== 1'b1 || ib.dout !== '0 || ib.dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: busy=%0b dout=%h valid=%0b, required 1/0000/0", ib.busy, ib.dout, ib.dout_valid);
        end
        qa.delete();
        qb.delete();
        last_a   = '0;
        last_b   = '0;
        clr_left = DEPTH;
        clr_idx  = 0;
        repeat (2) begin
            @(posedge clock);
            cyc++;
        end
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        tbl[0]  = '{1'b1, 3'd5, 14'h1ABC, 1'b0, 3'd0, 14'h0000, 14'h0000};
        tbl[1]  = '{1'b0, 3'd0, 14'h0000, 1'b1, 3'd5, 14'h1ABC, 14'h1ABC};
        tbl[2]  = '{1'b1, 3'd3, 14'h0011, 1'b0, 3'd0, 14'h0000, 14'h0000};
        tbl[3]  = '{1'b1, 3'd3, 14'h0022, 1'b1, 3'd3, 14'h0011, 14'h0022};
        tbl[4]  = '{1'b0, 3'd0, 14'h0000, 1'b1, 3'd3, 14'h0022, 14'h0022};
        tbl[5]  = '{1'b1, 3'd7, 14'h1234, 1'b1, 3'd5, 14'h1ABC, 14'h1ABC};
        tbl[6]  = '{1'b0, 3'd0, 14'h0000, 1'b1, 3'd7, 14'h1234, 14'h1234};
        tbl[7]  = '{1'b0, 3'd0, 14'h0000, 1'b1, 3'd0, 14'h0000, 14'h0155};
        tbl[8]  = '{1'b1, 3'd0, 14'h000A, 1'b0, 3'd0, 14'h0000, 14'h0000};
        tbl[9]  = '{1'b1, 3'd1, 14'h000B, 1'b0, 3'd0, 14'h0000, 14'h0000};
        tbl[10] = '{1'b1, 3'd2, 14'h000C, 1'b0, 3'd0, 14'h0000, 14'h0000};
        tbl[11] = '{1'b1, 3'd3, 14'h000D, 1'b0, 3'd0, 14'h0000, 14'h0000};
        tbl[12] = '{1'b0, 3'd0, 14'h0000, 1'b1, 3'd0, 14'h000A, 14'h000A};
        tbl[13] = '{1'b0, 3'd0, 14'h0000, 1'b1, 3'd1, 14'h000B, 14'h000B};
        tbl[14] = '{1'b0, 3'd0, 14'h0000, 1'b1, 3'd2, 14'h000C, 14'h000C};
        tbl[15] = '{1'b0, 3'd0, 14'h0000, 1'b1, 3'd3, 14'h000D, 14'h000D};
        tbl[16] = '{1'b1, 3'd6, 14'h3FFF, 1'b1, 3'd6, 14'h0000, 14'h3FFF};
        tbl[17] = '{1'b0, 3'd0, 14'h0000, 1'b1, 3'd6, 14'h3FFF, 14'h3FFF};

        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);

        // Power-up clear: 8 busy cycles; a write/read during busy is dropped.
        do_reset();
        tick(1'b1, 3'd2, 14'h2222, 1'b1, 3'd2, 1'b0, 1'b0, '0, '0);
        repeat (7) idle();
        for (int i = 0; i < 8; i++) rd(AW'(i));
        repeat (2) idle();

        // Directed vectors: write/read latency, collisions, back-to-back reads.
        for (int i = 0; i < NV; i++) begin
            tick(tbl[i].we, tbl[i].waddr, tbl[i].din, tbl[i].re, tbl[i].raddr,
                 1'b0, 1'b1, tbl[i].exp_a, tbl[i].exp_b);
        end
        repeat (3) idle();

        // Clear request over a full array; addr 0 is already cleared when the
        // stray write/read arrives, so a landed write would be visible.
        for (int i = 0; i < 8; i++) wr(AW'(i), 14'h3FFF);
        tick(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
        repeat (5) idle();
        tick(1'b1, 3'd0, 14'h3FFF, 1'b1, 3'd0, 1'b1, 1'b0, '0, '0);
        repeat (2) idle();
        for (int i = 0; i < 8; i++) rd(AW'(i));
        repeat (3) idle();

        // Reset during clear cycle 4: full 8-cycle clear after release.
        for (int i = 0; i < 8; i++) wr(AW'(i), 14'h2AAA);
        tick(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
        repeat (3) idle();
        do_reset();
        repeat (8) idle();
        for (int i = 0; i < 8; i++) rd(AW'(i));
        repeat (3) idle();

        // Reset right after a read: neither latency path may strobe.
        wr(3'd4, 14'h0777);
        rd(3'd4);
        do_reset();
        repeat (8) idle();
        rd(3'd4);
        repeat (3) idle();

        n_vec++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending a=%0d b=%0d, required 0/0", qa.size(), qb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sdp_sync_clr.md
Name: ram_sdp_sync_clr

Overview:
- Parameterised simple-dual-port (one write port, one read port) synchronous-read RAM for the tag/data store path.
- Adds separate read/write addresses, a read-valid strobe and an optional output pipeline register.
- Adds a configurable read-during-write collision mode.
- Adds a hardware clear engine that initialises every word after reset or on request. No file-based memory preload is used.

Parameters:
- AWIDTH, 3: address width; DEPTH = 1 << AWIDTH (localparam).
- DWIDTH, 14: data word width.
- OUT_REG, 0: 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
- RD_MODE, 0: same-address read/write collision. 0 = read-first (old data); 1 = write-first (new data).
- CLR_VALUE, 0: DWIDTH-bit value written to every word during clear.

Ports:
- clock, input, 1: system clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- clr_req, input, 1: request a full memory clear; sampled only in READY.
- busy, output, 1: high while clearing; user ports are ignored while busy=1.
- we, input, 1: write enable.
- waddr, input, AWIDTH: write address.
- din, input, DWIDTH: write data.
- re, input, 1: read enable.
- raddr, input, AWIDTH: read address.
- dout, output, DWIDTH: read data.
- dout_valid, output, 1: one-cycle strobe marking new data on dout.

Behaviour:
- Reset (reset_n=0, asynchronous assert):
  - FSM goes to CLEAR and clear counter clr_addr=0.
  - busy=1, dout=0, dout_valid=0, pipeline registers=0.
  - Memory array has no reset; its contents are overwritten by the clear engine.
- FSM has two states, CLEAR and READY.
- CLEAR:
  - Each cycle writes CLR_VALUE to mem[clr_addr], then clr_addr increments.
  - After the write to DEPTH-1, next state is READY and clr_addr wraps to 0.
  - Clear therefore takes exactly DEPTH cycles after reset_n deasserts.
  - busy=1 throughout CLEAR; busy=0 in the cycle READY is entered.
- READY:
  - clr_req=1 at a rising edge moves the FSM to CLEAR next cycle with clr_addr=0.
  - Any we/re in that same cycle is still honoured.
- While busy=1:
  - we and re are ignored; no user write lands and dout_valid stays 0.
  - clr_req is ignored; an in-progress clear is not restarted.
  - dout holds its value.
- Write: in READY with we=1, mem[waddr] <= din at the rising edge.
- Read, OUT_REG=0:
  - re=1 at edge N loads dout with mem[raddr] at edge N; dout_valid=1 for the following cycle only.
- Read, OUT_REG=1:
  - The same data passes through one more register; dout/dout_valid appear one cycle later (2-cycle latency).
  - Back-to-back reads are fully pipelined, one result per cycle.
- dout holds its last read value when no read completes. dout_valid=0 unless a read completes in that cycle.
- Collision (we=1, re=1, waddr==raddr, same edge):
  - RD_MODE=0: dout gets the pre-write contents.
  - RD_MODE=1: dout gets din.
  - The write always commits.
- Different-address simultaneous read and write are independent.
- Address wrap: addresses are AWIDTH bits; no out-of-range addresses exist. The clear counter wraps DEPTH-1 -> 0.
- Reset mid-clear or mid-read: asynchronous abort.
  - In-flight read results are discarded and dout_valid=0.
  - Clear restarts from address 0 after deassertion.
- Pipeline register on the OUT_REG=1 path resets to 0 with the valid bit cleared.

Test Plan:
- Reset release, default params: busy=1 for 8 cycles after reset_n rises, then 0. Read all 8 addresses -> each dout=14'h0000 with one dout_valid pulse per read.
- Write 14'h1ABC to addr 5, read addr 5 next cycle: OUT_REG=0 -> dout=14'h1ABC one cycle after re, dout_valid high 1 cycle. OUT_REG=1 -> appears 2 cycles after re.
- Collision: mem[3]=14'h0011; same cycle we=1, waddr=3, din=14'h0022, re=1, raddr=3. RD_MODE=0 -> dout=14'h0011; RD_MODE=1 -> dout=14'h0022. A later read of addr 3 returns 14'h0022 in both modes.
- Clear request: fill all words with 14'h3FFF, CLR_VALUE=14'h0155, pulse clr_req. Then busy=1 for 8 cycles, and a we/re issued during busy has no effect and produces no dout_valid. Afterwards all addresses read 14'h0155.
- Reset mid-operation:
  - Assert reset_n=0 during clear cycle 4 -> busy stays 1, dout=0, dout_valid=0 immediately. After release, busy lasts a full 8 cycles.
  - Assert reset_n=0 one cycle after a read with OUT_REG=1 -> no dout_valid pulse is emitted.
- Back-to-back reads, OUT_REG=1: re=1 on 4 consecutive cycles, addrs 0,1,2,3 holding 14'h0A,14'h0B,14'h0C,14'h0D. Expect 4 consecutive dout_valid cycles with dout in that order, starting 2 cycles after the first re.
